// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of serial_adder; master drives operands, slave returns the result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the serial adder's datapath cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit per clock LSB-first, one-cycle done pulse.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (a - b - cin).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           st, st_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] wk, wk_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit;
  logic             accept, last;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? ~bus.cin : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign accept = (st != RUN) && bus.start;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    st_nx    = st;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (st)
      IDLE: if (bus.start) st_nx = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) st_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        st_nx    = bus.start ? RUN : IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Sum bits enter at the top of wk; after WIDTH-1 shifts bit 0 sits at wk[0]
  // and the MSB comes straight from the cell on the final edge.
  always_comb begin
    wk_nx          = wk >> 1;
    wk_nx[WIDTH-2] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      wk       <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= b_in;
      carry <= c_in;
      wk    <= '0;
      cnt   <= '0;
    end else if (st == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_bit;
      wk    <= wk_nx;
      if (last) begin
        cnt      <= '0;
        bus.sum  <= {s_bit, wk};
        bus.cout <= c_bit;
        bus.ovf  <= carry ^ c_bit;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 2, 8 and 64 against an arithmetic reference.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(2))  i2 ();
  serial_adder_if #(.WIDTH(8))  i8 ();
  serial_adder_if #(.WIDTH(64)) i64 ();

  serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2));
  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_adder #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64));

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: signed/unsigned arithmetic on wide integers. Returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_op(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
    logic signed [67:0] pw, half, ua, ub, ci, sa, sb, u, r;
    logic [67:0] masked;
    logic do_sub, cout, ovf;
    do_sub = sub & SUB_EN;
    pw   = 68'sd1 <<< w;
    half = pw >>> 1;
    ua = {4'b0, a};
    ub = {4'b0, b};
    ua = ua & (pw - 68'sd1);
    ub = ub & (pw - 68'sd1);
    ci = {67'b0, cin};
    sa = (ua >= half) ? ua - pw : ua;
    sb = (ub >= half) ? ub - pw : ub;
    if (do_sub) begin
      u = ua - ub - ci;
      cout = (u >= 68'sd0);
      r = sa - sb - ci;
    end else begin
      u = ua + ub + ci;
      cout = (u >= pw);
      r = sa + sb + ci;
    end
    ovf = (r >= half) || (r < -half);
    masked = u & (pw - 68'sd1);
    return {ovf, cout, masked[63:0]};
  endfunction

  task automatic set_in(input int unsigned w, input logic st, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb);
    case (w)
      2:  begin i2.start = st;  i2.a = a[1:0];  i2.b = b[1:0];  i2.cin = ci;  i2.sub = sb;  end
      8:  begin i8.start = st;  i8.a = a[7:0];  i8.b = b[7:0];  i8.cin = ci;  i8.sub = sb;  end
      default: begin i64.start = st; i64.a = a; i64.b = b; i64.cin = ci; i64.sub = sb; end
    endcase
  endtask

  task automatic get_out(input int unsigned w, output logic busy, output logic done,
                         output logic [63:0] sum, output logic cout, output logic ovf);
    case (w)
      2:  begin busy = i2.busy;  done = i2.done;  sum = {62'b0, i2.sum};  cout = i2.cout;  ovf = i2.ovf;  end
      8:  begin busy = i8.busy;  done = i8.done;  sum = {56'b0, i8.sum};  cout = i8.cout;  ovf = i8.ovf;  end
      default: begin busy = i64.busy; done = i64.done; sum = i64.sum; cout = i64.cout; ovf = i64.ovf; end
    endcase
  endtask

  // Issues one operation and waits (bounded) for done; operands are scrambled after acceptance.
  task automatic run_op(input int unsigned w, input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input logic sb, output logic [63:0] sum, output logic co, output logic ov,
                        output int edges, output int busy_bad);
    logic busy, done;
    set_in(w, 1'b1, a, b, ci, sb);
    edges = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1)
        set_in(w, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), 1'($urandom()));
      get_out(w, busy, done, sum, co, ov);
      if (!done && !busy) busy_bad++;
    end while (!done && edges < int'(w) + 10);
  endtask

  task automatic test_reset();
    logic busy, done, cout, ovf;
    logic [63:0] sum;
    int unsigned ws[3] = '{2, 8, 64};
    rst_n = 1'b0;
    foreach (ws[i]) set_in(ws[i], 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    foreach (ws[i]) begin
      get_out(ws[i], busy, done, sum, cout, ovf);
      checks++;
      if ({busy, done, cout, ovf} !== 4'b0 || sum !== 64'd0) begin
        errors++;
        $display("FAIL reset_state w=%0d: busy=%b done=%b cout=%b ovf=%b sum=%h, required all 0",
                 ws[i], busy, done, cout, ovf, sum);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_vectors();
    logic [7:0] tv [4][3] = '{'{8'h7F, 8'h01, 8'h00}, '{8'hFF, 8'h01, 8'h01},
                              '{8'h80, 8'h80, 8'h00}, '{8'h00, 8'h00, 8'h01}};
    logic [9:0] exp [4] = '{{1'b1, 1'b0, 8'h80}, {1'b0, 1'b1, 8'h01},
                            {1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 8'h01}};
    logic [63:0] sum;
    logic co, ov;
    int edges, busy_bad;
    for (int i = 0; i < 4; i++) begin
      run_op(8, {56'b0, tv[i][0]}, {56'b0, tv[i][1]}, tv[i][2][0], 1'b0, sum, co, ov, edges, busy_bad);
      checks++;
      if ({ov, co, sum[7:0]} !== exp[i]) begin
        errors++;
        $display("FAIL add_vec%0d: got ovf/cout/sum=%b/%b/%h, required %b/%b/%h",
                 i, ov, co, sum[7:0], exp[i][9], exp[i][8], exp[i][7:0]);
      end
      checks++;
      if (edges !== 9 || busy_bad !== 0) begin
        errors++;
        $display("FAIL add_latency%0d: done after %0d edges (busy gaps %0d), required 9 (0)", i, edges, busy_bad);
      end
      @(negedge clk);
      checks++;
      if (i8.done !== 1'b0 || i8.sum !== exp[i][7:0]) begin
        errors++;
        $display("FAIL done_pulse%0d: done=%b sum=%h next cycle, required done=0 sum=%h",
                 i, i8.done, i8.sum, exp[i][7:0]);
      end
    end
  endtask

  task automatic test_sub();
`ifdef SERIAL_ADDER_SUB_EN
    logic [7:0] tv [3][3] = '{'{8'h05, 8'h07, 8'h00}, '{8'h80, 8'h01, 8'h00}, '{8'h00, 8'h00, 8'h01}};
    logic [9:0] exp [3] = '{{1'b0, 1'b0, 8'hFE}, {1'b1, 1'b1, 8'h7F}, {1'b0, 1'b0, 8'hFF}};
`else
    logic [7:0] tv [3][3] = '{'{8'h05, 8'h07, 8'h00}, '{8'h80, 8'h01, 8'h00}, '{8'h00, 8'h00, 8'h01}};
    logic [9:0] exp [3] = '{{1'b0, 1'b0, 8'h0C}, {1'b0, 1'b0, 8'h81}, {1'b0, 1'b0, 8'h01}};
`endif
    logic [63:0] sum;
    logic co, ov;
    int edges, busy_bad;
    for (int i = 0; i < 3; i++) begin
      run_op(8, {56'b0, tv[i][0]}, {56'b0, tv[i][1]}, tv[i][2][0], 1'b1, sum, co, ov, edges, busy_bad);
      checks++;
      if ({ov, co, sum[7:0]} !== exp[i]) begin
        errors++;
        $display("FAIL sub_vec%0d: got ovf/cout/sum=%b/%b/%h, required %b/%b/%h",
                 i, ov, co, sum[7:0], exp[i][9], exp[i][8], exp[i][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges = 0, t1 = 0, t2 = 0;
    logic [7:0] s1 = '0, s2 = '0, mid_sum = '0;
    logic mid_busy = 1'b0;
    set_in(8, 1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
    while (t2 == 0 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 1) set_in(8, 1'b1, 64'h01, 64'h01, 1'b0, 1'b0);
      if (edges == 14) begin mid_sum = i8.sum; mid_busy = i8.busy; end
      if (i8.done) begin
        if (t1 == 0) begin t1 = edges; s1 = i8.sum; end
        else begin t2 = edges; s2 = i8.sum; end
      end
    end
    set_in(8, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (t1 !== 9 || s1 !== 8'h30) begin
      errors++;
      $display("FAIL b2b_first: done at edge %0d sum=%h, required edge 9 sum=30", t1, s1);
    end
    checks++;
    if (mid_sum !== 8'h30 || mid_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: mid-run sum=%h busy=%b, required 30/1", mid_sum, mid_busy);
    end
    checks++;
    if (t2 - t1 !== 9 || s2 !== 8'h02) begin
      errors++;
      $display("FAIL b2b_second: spacing %0d sum=%h, required 9 and 02", t2 - t1, s2);
    end
    @(negedge clk);
    checks++;
    if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: done=%b busy=%b, required 0/0", i8.done, i8.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen = 0, edges, busy_bad;
    logic [63:0] sum;
    logic co, ov;
    set_in(8, 1'b1, 64'h55, 64'h11, 1'b0, 1'b0);
    @(negedge clk);
    set_in(8, 1'b0, 64'hAA, 64'hAA, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i8.busy, i8.done, i8.cout, i8.ovf} !== 4'b0 || i8.sum !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_clear: busy=%b done=%b cout=%b ovf=%b sum=%h, required all 0",
               i8.busy, i8.done, i8.cout, i8.ovf, i8.sum);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (i8.done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_nodone: %0d done pulses after abort, required 0", done_seen);
    end
    run_op(8, 64'h03, 64'h04, 1'b0, 1'b0, sum, co, ov, edges, busy_bad);
    checks++;
    if (sum[7:0] !== 8'h07 || co !== 1'b0 || ov !== 1'b0 || edges !== 9) begin
      errors++;
      $display("FAIL mid_reset_fresh: sum=%h cout=%b ovf=%b edges=%0d, required 07/0/0/9", sum[7:0], co, ov, edges);
    end
  endtask

  task automatic test_random_sweep(input int unsigned w, input int n);
    logic [63:0] a, b, sum, mask;
    logic ci, sb, co, ov;
    logic [65:0] exp;
    int edges, busy_bad;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < n; i++) begin
      a  = {$urandom(), $urandom()} & mask;
      b  = {$urandom(), $urandom()} & mask;
      ci = 1'($urandom());
      sb = 1'($urandom());
      exp = ref_op(w, a, b, ci, sb);
      run_op(w, a, b, ci, sb, sum, co, ov, edges, busy_bad);
      checks++;
      if (sum !== exp[63:0] || co !== exp[64] || ov !== exp[65]) begin
        errors++;
        $display("FAIL rand_w%0d_%0d a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b, required %h/%b/%b",
                 w, i, a, b, ci, sb, sum, co, ov, exp[63:0], exp[64], exp[65]);
      end
      checks++;
      if (edges !== int'(w) + 1 || busy_bad !== 0) begin
        errors++;
        $display("FAIL rand_lat_w%0d_%0d: done after %0d edges (busy gaps %0d), required %0d (0)",
                 w, i, edges, busy_bad, w + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep(2, 40);
    test_random_sweep(8, 40);
    test_random_sweep(64, 25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
